// File: rtl/popcount_ternary_acc_pkg.sv
// popcount_pkg: shared helpers for the ternary popcount accumulator.
//   clog2_f   - elaboration-time ceil(log2(v)); clog2_f(1) = 0
//   IN_W_DEF  - default bits per beat
//   BEATS_DEF - default maximum beats per vector
//   delta_t   - signed per-beat delta at the default width
package popcount_pkg;

    localparam int IN_W_DEF  = 20;
    localparam int BEATS_DEF = 4;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int CNT_W_DEF = clog2_f(IN_W_DEF + 1);

    // Delta spans -IN_W..+IN_W, so one bit wider than the popcount.
    // Non-default instances size their own delta from IN_W.
    typedef logic signed [CNT_W_DEF:0] delta_t;

endpackage

// File: rtl/popcount_ternary_acc_tree.sv
// popcount_tree: exact combinational popcount built as a balanced binary adder tree.
// Ports:
//   bits  in   W      input vector
//   cnt   out  CNT_W  number of set bits, CNT_W = clog2(W+1)
// The interface is kept minimal so an approximate tree can be dropped in later.
module popcount_tree
    import popcount_pkg::*;
#(
    parameter int W     = IN_W_DEF,
    parameter int CNT_W = clog2_f(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] cnt
);

    // Heap-ordered tree: leaves at [P-1 .. 2P-2], node i sums children 2i+1 and 2i+2.
    // No partial sum can exceed W, so CNT_W bits are enough at every level.
    localparam int P = 1 << clog2_f(W);

    logic [CNT_W-1:0] node [0:2*P-2];

    genvar i;
    generate
        for (i = 0; i < P; i++) begin : g_leaf
            if (i < W) begin : g_bit
                assign node[P-1+i] = CNT_W'(bits[i]);
            end else begin : g_pad
                assign node[P-1+i] = '0;
            end
        end
        for (i = 0; i < P-1; i++) begin : g_sum
            assign node[i] = node[2*i+1] + node[2*i+2];
        end
    endgenerate

    assign cnt = node[0];

endmodule

// File: rtl/popcount_ternary_acc.sv
// popcount_ternary_acc: ternary-neuron accumulator. Each accepted beat adds
// popcount(pos & ~neg) - popcount(neg & ~pos) to a signed accumulator. On the
// final beat (in_last, or the BEATS-th beat) the sum, its threshold
// activation and the beat count are registered on the output.
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    beat handshake
//   in_pos/in_neg        +1 / -1 masks, IN_W bits each
//   in_last              final beat of the vector
//   thresh               signed threshold, taken on the accepted final beat
//   out_valid/out_ready  result handshake
//   out_sum              signed vector sum, ACC_W bits
//   out_act              out_sum >= thresh (signed)
//   out_beats            beats in the vector
module popcount_ternary_acc
    import popcount_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int BEATS = BEATS_DEF,
    localparam int CNT_W = clog2_f(IN_W + 1),
    localparam int ACC_W = clog2_f(IN_W * BEATS + 1) + 1,
    localparam int BW    = clog2_f(BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_pos,
    input  logic [IN_W-1:0]         in_neg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thresh,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_act,
    output logic [BW-1:0]           out_beats
);

    logic [CNT_W-1:0]        cnt_pos, cnt_neg;
    logic signed [CNT_W:0]   delta;
    logic signed [ACC_W-1:0] acc, sum;
    logic [BW-1:0]           beat_cnt;
    logic                    accept, final_beat;

    // Bits set in both masks cancel, so mask them out before counting.
    popcount_tree #(.W(IN_W), .CNT_W(CNT_W)) u_pos (
        .bits (in_pos & ~in_neg),
        .cnt  (cnt_pos)
    );
    popcount_tree #(.W(IN_W), .CNT_W(CNT_W)) u_neg (
        .bits (in_neg & ~in_pos),
        .cnt  (cnt_neg)
    );

    assign delta      = $signed({1'b0, cnt_pos}) - $signed({1'b0, cnt_neg});
    assign sum        = acc + ACC_W'(delta);   // sign-extending cast
    // Hold state is simply out_valid with no consumer; consume and reload may overlap.
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign final_beat = in_last || (beat_cnt == BW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_act   <= 1'b0;
            out_beats <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (final_beat) begin
                    out_sum   <= sum;
                    out_act   <= (sum >= thresh);
                    out_beats <= beat_cnt + BW'(1);
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                end else begin
                    acc       <= sum;
                    beat_cnt  <= beat_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_ternary_acc.sv
module tb_popcount_ternary_acc;

    localparam int IN_W  = 20;
    localparam int BEATS = 4;
    localparam int ACC_W = 8;   // clog2(81)+1
    localparam int BW    = 3;   // clog2(5)

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid, in_ready, in_last, out_valid, out_ready, out_act;
    logic [IN_W-1:0]         in_pos, in_neg;
    logic signed [ACC_W-1:0] thresh, out_sum;
    logic [BW-1:0]           out_beats;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    popcount_ternary_acc #(.IN_W(IN_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_act(out_act), .out_beats(out_beats)
    );

    typedef struct {
        int              nb;
        logic [3:0][19:0] pos;
        logic [3:0][19:0] neg;
        bit              use_last;
        bit              gap;
        int              thr;
        int              esum;
        int              eact;
        int              ebeats;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one beat at a negedge, wait (bounded) for in_ready, return at the
    // negedge after the accepting posedge with in_valid dropped.
    task automatic send_beat(input logic [19:0] p, input logic [19:0] n,
                             input logic l, input int thr);
        int t;
        in_valid = 1'b1; in_pos = p; in_neg = n; in_last = l; thresh = ACC_W'(thr);
        t = 0;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 50) chk("beat_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input int nb, input logic [3:0][19:0] p, input logic [3:0][19:0] n,
                                input bit ul, input bit gap, input int thr,
                                input int es, input int ea, input int eb);
        vec_t v;
        v.nb = nb; v.pos = p; v.neg = n; v.use_last = ul; v.gap = gap;
        v.thr = thr; v.esum = es; v.eact = ea; v.ebeats = eb;
        return v;
    endfunction

    // Reference model state for the random phase.
    int  m_acc, m_cnt, m_sum, m_act, m_beats, d, s;
    bit  m_valid, ordy, iv, il, rdy;
    logic [19:0] rp, rn;
    int  rthr;

    initial begin
        // 4 beats full pos, forced end
        vecs.push_back(mk(4, {4{20'hFFFFF}}, {4{20'h0}}, 0, 0, 80, 80, 1, 4));
        vecs.push_back(mk(4, {4{20'hFFFFF}}, {4{20'h0}}, 0, 1, 81, 80, 0, 4));
        // single beat: pos&~neg=0, neg&~pos=0xF0 -> -4
        vecs.push_back(mk(1, {4{20'h0000F}}, {4{20'h000FF}}, 1, 0, -4, -4, 1, 1));
        // full overlap cancels
        vecs.push_back(mk(1, {4{20'hFFFFF}}, {4{20'hFFFFF}}, 1, 0, 1, 0, 0, 1));
        // 2 beats: +2 then -3
        vecs.push_back(mk(2, {20'h0, 20'h0, 20'h0, 20'h00003}, {20'h0, 20'h0, 20'h00007, 20'h0},
                          1, 1, 0, -1, 0, 2));
        vecs.push_back(mk(3, {4{20'hFFFFF}}, {4{20'h0}}, 1, 0, 61, 60, 0, 3));
        // most negative sum
        vecs.push_back(mk(4, {4{20'h0}}, {4{20'hFFFFF}}, 0, 0, -80, -80, 1, 4));
        vecs.push_back(mk(1, {4{20'h80001}}, {4{20'h00001}}, 1, 0, -128, 1, 1, 1));

        // ---- reset, with in_valid held high
        rst_n = 1'b0; in_valid = 1'b1; in_pos = 20'hFFFFF; in_neg = '0; in_last = 1'b1;
        thresh = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_act", out_act, 0);
        chk("rst_out_beats", out_beats, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        chk("rst_no_output", out_valid, 0);

        // ---- table vectors, out_ready held 1
        foreach (vecs[k]) begin
            for (int b = 0; b < vecs[k].nb; b++) begin
                send_beat(vecs[k].pos[b], vecs[k].neg[b],
                          vecs[k].use_last && (b == vecs[k].nb - 1), vecs[k].thr);
                if (vecs[k].gap && b < vecs[k].nb - 1) @(negedge clk);
            end
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_sum", k), out_sum, vecs[k].esum);
            chk($sformatf("vec%0d_act", k), out_act, vecs[k].eact);
            chk($sformatf("vec%0d_beats", k), out_beats, vecs[k].ebeats);
        end
        @(negedge clk);
        chk("drain_valid", out_valid, 0);

        // ---- forced end, then the 5th beat starts a fresh vector
        for (int b = 0; b < 4; b++) send_beat(20'h00001, 20'h0, 1'b0, 0);
        chk("force_sum", out_sum, 4);
        chk("force_beats", out_beats, 4);
        send_beat(20'h00003, 20'h0, 1'b1, 0);
        chk("after_force_sum", out_sum, 2);
        chk("after_force_beats", out_beats, 1);
        @(negedge clk);

        // ---- backpressure then consume-and-reload in the same cycle
        out_ready = 1'b0;
        send_beat(20'h00007, 20'h0, 1'b1, 0);
        in_valid = 1'b1; in_pos = 20'h0001F; in_neg = '0; in_last = 1'b1; thresh = ACC_W'(6);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 3);
            chk("bp_beats", out_beats, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nobubble_valid", out_valid, 1);
        chk("nobubble_sum", out_sum, 5);
        chk("nobubble_act", out_act, 0);
        @(negedge clk);
        chk("nobubble_drain", out_valid, 0);

        // ---- reset mid-vector discards the partial sum
        send_beat(20'hFFFFF, 20'h0, 1'b0, 0);
        send_beat(20'hFFFFF, 20'h0, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", out_valid, 0);
        send_beat(20'h00001, 20'h0, 1'b1, 0);
        chk("midrst_sum", out_sum, 1);
        chk("midrst_beats", out_beats, 1);
        @(negedge clk);

        // ---- random traffic against a cycle-level reference model
        m_acc = 0; m_cnt = 0; m_valid = 0; m_sum = 0; m_act = 0; m_beats = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_valid", out_valid, int'(m_valid));
            if (m_valid) begin
                chk("rnd_sum", out_sum, m_sum);
                chk("rnd_act", out_act, m_act);
                chk("rnd_beats", out_beats, m_beats);
            end
            ordy = ($urandom_range(3) != 0);
            iv   = ($urandom_range(2) != 0);
            il   = ($urandom_range(3) == 0);
            rp   = 20'($urandom) & (($urandom_range(1) != 0) ? 20'hFFFFF : 20'h0F0F3);
            rn   = 20'($urandom);
            rthr = $urandom_range(160) - 80;
            out_ready = ordy; in_valid = iv; in_last = il; in_pos = rp; in_neg = rn;
            thresh = ACC_W'(rthr);
            rdy = !m_valid || ordy;
            #1;
            chk("rnd_in_ready", in_ready, int'(rdy));
            if (m_valid && ordy) m_valid = 0;
            if (iv && rdy) begin
                d = $countones(rp & ~rn) - $countones(rn & ~rp);
                s = m_acc + d;
                if (il || m_cnt == BEATS - 1) begin
                    m_sum = s; m_act = (s >= rthr) ? 1 : 0; m_beats = m_cnt + 1;
                    m_valid = 1; m_acc = 0; m_cnt = 0;
                end else begin
                    m_acc = s; m_cnt++;
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
